wc_pin_host: RTL and testbench

- Host-side companion to the pad-wrapped WC_6_3 Winograd chip.
- Buffers one input frame from a local valid/ready stream: 8 data samples followed by 3 filter taps.
- Bursts the frame onto the chip's 10-bit D pins behind a sync word, waits the core's fixed latency, then captures 6 result words from the Z pins.
- Returns the results on a local valid/ready stream; the block sits in the FPGA/tester harness that drives the CHIP.

---
 rtl/wc_host_pkg.sv | 19 +
 rtl/wc_host_wordbuf.sv | 51 +++++
 rtl/wc_pin_host.sv | 211 +++++++++++++++++++++
 tb/tb_wc_pin_host.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wc_host_pkg.sv
// Shared types and default frame geometry for the WC_6_3 host-side pin driver.
package wc_host_pkg;

  localparam int DEF_W     = 10;
  localparam int DEF_N_IN  = 11;
  localparam int DEF_N_OUT = 6;
  localparam logic [DEF_W-1:0] DEF_SYNC = 10'h3FF;

  typedef logic [DEF_W-1:0] word_t;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    RECV  = 3'd3,
    DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/wc_host_wordbuf.sv
// DEPTH x W register file with one write port and a combinational read mux.
module wc_host_wordbuf
  import wc_host_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_N_IN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // Next contents: one word replaced on an in-range write.
  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < DEPTH)) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage; reset clears every entry so stale frames never leak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read mux.
  always_comb begin
    if (32'(raddr) < DEPTH) begin
      rdata = mem_q[raddr];
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/wc_pin_host.sv
// Host-side frame driver for the WC_6_3 chip: load, burst onto D, wait, capture Z, drain.
// Optional statistics (frame_cnt, sync_err) are built when WC_HOST_STATS_EN is defined.
module wc_pin_host
  import wc_host_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int N_IN     = DEF_N_IN,
  parameter int N_OUT    = DEF_N_OUT,
  parameter int CORE_LAT = 4,
  parameter logic [W-1:0] SYNC = DEF_SYNC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] d_pin,
  input  logic [W-1:0] z_pin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
`ifdef WC_HOST_STATS_EN
  ,
  output logic [15:0]  frame_cnt,
  output logic         sync_err
`endif
);

  localparam int IW = $clog2(N_IN);
  localparam int SW = $clog2(N_IN + 1);
  localparam int OW = $clog2(N_OUT);
  localparam int TW = $clog2((CORE_LAT > 1) ? CORE_LAT : 2);

  state_t         state_q, state_d;
  logic [IW-1:0]  wcnt_q, wcnt_d;
  logic [SW-1:0]  scnt_q, scnt_d;
  logic [TW-1:0]  wt_q, wt_d;
  logic [OW-1:0]  rcnt_q, rcnt_d;
  logic [OW-1:0]  rdptr_q, rdptr_d;
  logic [W-1:0]   d_pin_q, d_pin_d;

  logic           ibuf_we_s;
  logic           obuf_we_s;
  logic [IW-1:0]  ibuf_raddr_s;
  logic [W-1:0]   ibuf_rdata_s;
  logic [W-1:0]   obuf_rdata_s;

  assign ibuf_we_s    = (state_q == LOAD) && in_valid;
  assign obuf_we_s    = (state_q == RECV);
  // Slot 0 of the burst is SYNC, so the data read address trails the send count by one.
  assign ibuf_raddr_s = IW'(scnt_q - SW'(1));

  wc_host_wordbuf #(.W(W), .DEPTH(N_IN), .AW(IW)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .we    (ibuf_we_s),
    .waddr (wcnt_q),
    .wdata (in_data),
    .raddr (ibuf_raddr_s),
    .rdata (ibuf_rdata_s)
  );

  wc_host_wordbuf #(.W(W), .DEPTH(N_OUT), .AW(OW)) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .we    (obuf_we_s),
    .waddr (rcnt_q),
    .wdata (z_pin),
    .raddr (rdptr_q),
    .rdata (obuf_rdata_s)
  );

  // Next-state, counters and next D pin value.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    wt_d    = wt_q;
    rcnt_d  = rcnt_q;
    rdptr_d = rdptr_q;
    d_pin_d = '0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (wcnt_q == IW'(N_IN - 1)) begin
            wcnt_d  = '0;
            scnt_d  = '0;
            state_d = SEND;
          end else begin
            wcnt_d = wcnt_q + IW'(1);
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      SEND: begin
        d_pin_d = (scnt_q == SW'(0)) ? SYNC : ibuf_rdata_s;
        if (scnt_q == SW'(N_IN)) begin
          scnt_d  = '0;
          wt_d    = '0;
          state_d = (CORE_LAT == 1) ? RECV : WAIT;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      WAIT: begin
        if (wt_q == TW'(CORE_LAT - 2)) begin
          wt_d    = '0;
          state_d = RECV;
        end else begin
          wt_d = wt_q + TW'(1);
        end
      end
      RECV: begin
        if (rcnt_q == OW'(N_OUT - 1)) begin
          rcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          rcnt_d = rcnt_q + OW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rdptr_q == OW'(N_OUT - 1)) begin
            rdptr_d = '0;
            state_d = LOAD;
          end else begin
            rdptr_d = rdptr_q + OW'(1);
          end
        end else begin
          rdptr_d = rdptr_q;
        end
      end
      default: begin
        state_d = LOAD;
        wcnt_d  = '0;
        scnt_d  = '0;
        wt_d    = '0;
        rcnt_d  = '0;
        rdptr_d = '0;
      end
    endcase
  end

  // State, counters and the registered D pad drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      wt_q    <= '0;
      rcnt_q  <= '0;
      rdptr_q <= '0;
      d_pin_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      wt_q    <= wt_d;
      rcnt_q  <= rcnt_d;
      rdptr_q <= rdptr_d;
      d_pin_q <= d_pin_d;
    end
  end

  assign d_pin     = d_pin_q;
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (rdptr_q == OW'(N_OUT - 1));
  assign out_data  = (state_q == DRAIN) ? obuf_rdata_s : '0;

`ifdef WC_HOST_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sync_err_q, sync_err_d;
  logic        frame_done_s;

  assign frame_done_s = (state_q == DRAIN) && out_ready && (rdptr_q == OW'(N_OUT - 1));

  // Frame counter wraps naturally; sync_err is sticky until reset.
  always_comb begin
    if (frame_done_s) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if ((state_q == RECV) && (z_pin == SYNC)) begin
      sync_err_d = 1'b1;
    end else begin
      sync_err_d = sync_err_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 16'd0;
      sync_err_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign sync_err  = sync_err_q;
`endif

endmodule

// File: tb/tb_wc_pin_host.sv
// Bench for wc_pin_host: two instances (CORE_LAT 4 and 1), each with a chip model and scoreboard.
module tb_wc_pin_host;
  import wc_host_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid_s  [2];
  logic       in_ready_s  [2];
  logic [9:0] in_data_s   [2];
  logic [9:0] d_pin_s     [2];
  logic [9:0] z_pin_s     [2];
  logic       out_valid_s [2];
  logic       out_ready_s [2];
  logic [9:0] out_data_s  [2];
  logic       out_last_s  [2];
  logic       busy_s      [2];
`ifdef WC_HOST_STATS_EN
  logic [15:0] frame_cnt_s [2];
  logic        sync_err_s  [2];
`endif

  int checks = 0;
  int failures = 0;
  logic [9:0] sent_w [2][11];
  bit nominal_mode = 1'b0;
  bit force_sync = 1'b0;
  int bp_mode [2];
  int frames_done [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 4 : 1;

    wc_pin_host #(.CORE_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .in_data   (in_data_s[g]),
      .d_pin     (d_pin_s[g]),
      .z_pin     (z_pin_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .out_data  (out_data_s[g]),
      .out_last  (out_last_s[g]),
      .busy      (busy_s[g])
`ifdef WC_HOST_STATS_EN
      ,
      .frame_cnt (frame_cnt_s[g]),
      .sync_err  (sync_err_s[g])
`endif
    );

    int cstate = 0;
    int ccnt = 0;
    int m = 0;
    int k = 0;
    int oidx = 0;
    bit hold = 1'b0;
    logic [9:0] hold_d;
    logic [9:0] res [6];
    logic [9:0] exp_q [$];
    logic [9:0] e;

    // Consumer readiness, changed just after each rising edge.
    always @(posedge clk) begin
      #1;
      case (bp_mode[g])
        0:       out_ready_s[g] = 1'b1;
        1:       out_ready_s[g] = 1'($urandom_range(0, 1));
        default: out_ready_s[g] = 1'b0;
      endcase
    end

    // Chip model (sees the D burst, answers on Z after LAT) and result scoreboard.
    always @(negedge clk) begin
      if (!rst) begin
        cstate = 0; ccnt = 0; m = 0; oidx = 0; hold = 1'b0;
        exp_q.delete();
        z_pin_s[g] = 10'h2AA;
      end else begin
        z_pin_s[g] = 10'h2AA;
        if (cstate == 1) begin
          chk($sformatf("u%0d_burst_word%0d", g, ccnt), 32'(d_pin_s[g]), 32'(sent_w[g][ccnt]));
          ccnt++;
          if (ccnt == 11) begin
            for (int j = 0; j < 6; j++) begin
              res[j] = nominal_mode ? 10'(32'h100 + j) : 10'($urandom_range(0, 1022));
              if (force_sync && j == 2) res[j] = 10'h3FF;
              exp_q.push_back(res[j]);
            end
            cstate = 2;
            m = 0;
          end
        end else if (cstate == 2) begin
          chk($sformatf("u%0d_d_after_burst", g), 32'(d_pin_s[g]), 32'd0);
        end else begin
          if (d_pin_s[g] == 10'h3FF) begin
            cstate = 1;
            ccnt = 0;
          end else begin
            chk($sformatf("u%0d_d_idle", g), 32'(d_pin_s[g]), 32'd0);
          end
        end
        if (cstate == 2) begin
          k = m - (LAT - 1);
          if (k >= 0 && k < 6) z_pin_s[g] = res[k];
          if (k == 5) cstate = 0;
          m++;
        end

        if (hold) chk($sformatf("u%0d_valid_held", g), 32'(out_valid_s[g]), 32'd1);
        if (out_valid_s[g]) begin
          chk($sformatf("u%0d_in_ready_drain", g), 32'(in_ready_s[g]), 32'd0);
          if (hold) chk($sformatf("u%0d_data_held", g), 32'(out_data_s[g]), 32'(hold_d));
          if (out_ready_s[g]) begin
            chk($sformatf("u%0d_out_pending", g), 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk($sformatf("u%0d_out_data%0d", g, oidx), 32'(out_data_s[g]), 32'(e));
            end
            chk($sformatf("u%0d_out_last%0d", g, oidx), 32'(out_last_s[g]), 32'(oidx == 5));
            if (oidx == 5) begin
              oidx = 0;
              frames_done[g]++;
            end else begin
              oidx++;
            end
            hold = 1'b0;
          end else begin
            hold = 1'b1;
            hold_d = out_data_s[g];
          end
        end else begin
          chk($sformatf("u%0d_last_idle", g), 32'(out_last_s[g]), 32'd0);
        end
      end
    end
  end

  task automatic send_frame(input int un, input bit gaps, input bit nominal);
    int i;
    int guard;
    bit acc;
    nominal_mode = nominal;
    for (int n = 0; n < 11; n++) begin
      sent_w[un][n] = nominal ? 10'(n + 1) : 10'($urandom_range(0, 1023));
    end
    i = 0;
    guard = 0;
    @(posedge clk); #1;
    while (i < 11 && guard < 400) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid_s[un] = 1'b0;
        in_data_s[un]  = 10'($urandom_range(0, 1023));
      end else begin
        in_valid_s[un] = 1'b1;
        in_data_s[un]  = sent_w[un][i];
      end
      @(negedge clk);
      acc = in_valid_s[un] && in_ready_s[un];
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    in_valid_s[un] = 1'b0;
    chk($sformatf("u%0d_load_timeout", un), 32'(i), 32'd11);
  endtask

  task automatic wait_frames(input int un, input int n);
    int guard;
    guard = 0;
    while (frames_done[un] < n && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    chk($sformatf("u%0d_frame_timeout", un), 32'(frames_done[un] >= n), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int guard;
    for (int n = 0; n < 2; n++) begin
      in_valid_s[n] = 1'b0;
      in_data_s[n] = 10'd0;
      bp_mode[n] = 0;
      frames_done[n] = 0;
    end

    #2 rst = 1'b0;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("u%0d_rst_d_pin", n), 32'(d_pin_s[n]), 32'd0);
      chk($sformatf("u%0d_rst_in_ready", n), 32'(in_ready_s[n]), 32'd1);
      chk($sformatf("u%0d_rst_out_valid", n), 32'(out_valid_s[n]), 32'd0);
      chk($sformatf("u%0d_rst_out_last", n), 32'(out_last_s[n]), 32'd0);
      chk($sformatf("u%0d_rst_out_data", n), 32'(out_data_s[n]), 32'd0);
      chk($sformatf("u%0d_rst_busy", n), 32'(busy_s[n]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Nominal frame: 1..11 in, 100..105 out.
    send_frame(0, 1'b0, 1'b1);
    wait_frames(0, 1);

    // Random data with input gaps and random backpressure.
    bp_mode[0] = 1;
    for (int f = 0; f < 3; f++) begin
      send_frame(0, 1'b1, 1'b0);
      wait_frames(0, 2 + f);
    end
    bp_mode[0] = 0;

    // Directed backpressure: consumer stalls five cycles on the first result.
    bp_mode[0] = 2;
    send_frame(0, 1'b0, 1'b1);
    guard = 0;
    while (!out_valid_s[0] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_valid_seen", 32'(out_valid_s[0]), 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", 32'(out_valid_s[0]), 32'd1);
      chk("bp_out_data", 32'(out_data_s[0]), 32'h100);
      chk("bp_in_ready", 32'(in_ready_s[0]), 32'd0);
      @(negedge clk);
    end
    bp_mode[0] = 0;
    wait_frames(0, 5);

    // CORE_LAT=1 instance.
    send_frame(1, 1'b0, 1'b1);
    wait_frames(1, 1);
    bp_mode[1] = 1;
    for (int f = 0; f < 2; f++) begin
      send_frame(1, 1'b1, 1'b0);
      wait_frames(1, 2 + f);
    end
    bp_mode[1] = 0;

    // Reset while the sixth burst word is on the pins.
    send_frame(0, 1'b0, 1'b0);
    guard = 0;
    while (!(u[0].cstate == 1 && u[0].ccnt == 6) && guard < 100) begin
      @(negedge clk); #2;
      guard++;
    end
    chk("midsend_reached", 32'(u[0].ccnt), 32'd6);
    rst = 1'b0;
    #1;
    chk("midsend_rst_d_pin", 32'(d_pin_s[0]), 32'd0);
    chk("midsend_rst_in_ready", 32'(in_ready_s[0]), 32'd1);
    chk("midsend_rst_busy", 32'(busy_s[0]), 32'd0);
    chk("midsend_rst_out_valid", 32'(out_valid_s[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    send_frame(0, 1'b1, 1'b0);
    wait_frames(0, 6);

`ifdef WC_HOST_STATS_EN
    pulse_reset();
    send_frame(0, 1'b0, 1'b0);
    wait_frames(0, 7);
    chk("stats_sync_err_f1", 32'(sync_err_s[0]), 32'd0);
    chk("stats_frame_cnt_f1", 32'(frame_cnt_s[0]), 32'd1);
    force_sync = 1'b1;
    send_frame(0, 1'b0, 1'b0);
    wait_frames(0, 8);
    force_sync = 1'b0;
    chk("stats_sync_err_f2", 32'(sync_err_s[0]), 32'd1);
    send_frame(0, 1'b1, 1'b0);
    wait_frames(0, 9);
    chk("stats_sync_err_f3", 32'(sync_err_s[0]), 32'd1);
    chk("stats_frame_cnt_f3", 32'(frame_cnt_s[0]), 32'd3);
    chk("stats_u1_frame_cnt", 32'(frame_cnt_s[1]), 32'd0);
    chk("stats_u1_sync_err", 32'(sync_err_s[1]), 32'd0);
`endif

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
